encoder_4_to_2_seq: RTL and testbench
=====================================

Name: encoder_4_to_2_seq

Overview:
- Registered priority encoder: the encode-side counterpart of the team's 2-to-4 decoder.
- Collects request pulses on a 4-bit one-hot-style request bus into a pending register.
- Emits the index of the highest-priority pending request as a 2-bit code, with a valid/ready handshake.
- Sits in front of the decoder or any index consumer; encoder output y fed to the decoder reproduces the original line.

Parameters:
- N_REQ, 4, number of request lines; must be a power of two, at least 2.
- IDX_W, 2, width of encoded index; equals log2(N_REQ).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  request capture enable; when 0, req is ignored; handshake still proceeds.
- req  input  N_REQ  request lines; bit i high for one or more cycles requests index i.
- out_ready  input  1  consumer accepts y this cycle when out_valid=1.
- y  output  IDX_W  encoded index of the selected request.
- out_valid  output  1  y is valid.
- any  output  1  registered OR of the pending register after update.
- ovf  output  1  sticky overflow: a request hit an already-pending bit.

Behaviour:
Reset (rst=1 at a rising edge):
- pending=0, y=0, out_valid=0, any=0, ovf=0, state=IDLE.
- Reset overrides every other input in the same cycle, including mid-handshake; no accept is counted.

Per-cycle definitions:
- acc = out_valid & out_ready.
- clr = one-hot(y) if acc, else 0.
- cap = req if en, else 0.
- pnext = (pending & ~clr) | cap.
- pending <= pnext.
- any <= |pnext.

Priority:
- Highest index wins: req[3] > req[2] > req[1] > req[0].
- pri(v) is the index of the most-significant set bit of v.

State machine:
- IDLE (out_valid=0):
  - pnext != 0: y <= pri(pnext), out_valid <= 1, go to VALID.
  - Otherwise stay in IDLE.
- VALID (out_valid=1):
  - y is held stable and out_valid stays 1 until acc.
  - acc with pnext != 0: y <= pri(pnext), stay in VALID. Back-to-back throughput is one index per cycle.
  - acc with pnext == 0: out_valid <= 0, go to IDLE. y holds its last value.
  - No acc: no change to y, even if a higher-priority request arrives. Higher priority takes effect only at the next selection.

Latency and pending behaviour:
- Latency: a req sampled at edge k with en=1 in IDLE gives out_valid=1 and the corresponding y after edge k.
- A request stays pending until its index is accepted. Lower-priority requests are never dropped; they are served after higher ones drain.

Overflow (ovf):
- ovf <= ovf | (|(cap & pending & ~clr)).
- A request to a bit being cleared by acc in the same cycle is not overflow; that bit re-arms (stays set in pnext).
- ovf clears only on rst.

Simultaneous events:
- acc plus a new request on the same index: the index is re-presented next cycle (valid stays 1, y unchanged).
- en=0 with req active: nothing captured, ovf unaffected.

Width rules:
- y is IDX_W bits.
- The internal state needs only 1 bit (IDLE/VALID).

Test Plan:
1. Reset then single request: rst=1 for 2 cycles, then req=0100, en=1 for 1 cycle, out_ready=0.
   -> after that edge: y=10, out_valid=1, any=1; held for 5 cycles.
   -> out_ready=1 for 1 cycle: out_valid=0, any=0.
2. Priority and drain order: req=1011 for 1 cycle, out_ready=1 continuously.
   -> y sequence 11, 01, 00 on consecutive cycles with out_valid=1, then out_valid=0. Encoder-to-decoder loopback gives y lines 3, 1, 0 in turn.
3. Overflow: req=0001 on two consecutive cycles with out_ready=0.
   -> ovf=1 after the second edge and stays 1 until rst.
   -> req=0001 coinciding with the accept of y=00 leaves ovf=0 and re-presents y=00.
4. Enable gating: en=0, req=1111 for 3 cycles.
   -> out_valid=0, any=0, ovf=0.
   -> then en=1 for 1 cycle: y=11, out_valid=1.
5. Hold-stable rule: y=01 valid with out_ready=0; assert req=1000.
   -> y stays 01 until accept; the next cycle shows y=11.
6. Reset mid-operation: pending=1110, out_valid=1; rst=1 for 1 cycle with out_ready=1 and req=0001.
   -> all outputs 0, pending=0 after the edge; no request survives.

Source files
------------

// File: rtl/encoder_4_to_2_seq_if.sv
`default_nettype none
// ============================================================================
// Module  : encoder_4_to_2_seq_if
// Brief   : Request capture and encoded-index handshake bundle for the
//           registered priority encoder.
// Revision: 1.0 - initial release
// ============================================================================
interface encoder_4_to_2_seq_if #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
);
    logic             en;
    logic [N_REQ-1:0] req;
    logic             out_ready;
    logic [IDX_W-1:0] y;
    logic             out_valid;
    logic             any;
    logic             ovf;

    // The encoder is the master of the encoded-index stream.
    modport master (
        input  en,
        input  req,
        input  out_ready,
        output y,
        output out_valid,
        output any,
        output ovf
    );

    modport slave (
        output en,
        output req,
        output out_ready,
        input  y,
        input  out_valid,
        input  any,
        input  ovf
    );
endinterface
`default_nettype wire

// File: rtl/encoder_4_to_2_seq.sv
`default_nettype none
// ============================================================================
// Module  : encoder_4_to_2_seq
// Brief   : Registered priority encoder; accumulates request pulses and
//           presents the highest pending index over a valid/ready handshake.
// Revision: 1.0 - initial release
// ============================================================================
module encoder_4_to_2_seq #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  wire logic              clk,
    input  wire logic              rst,
    encoder_4_to_2_seq_if.master   bus
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_VALID = 1'b1
    } state_t;

    state_t           r_state;
    logic [N_REQ-1:0] r_pending;
    logic [IDX_W-1:0] r_y;
    logic             r_valid;
    logic             r_any;
    logic             r_ovf;

    logic             w_acc;
    logic [N_REQ-1:0] w_clr;
    logic [N_REQ-1:0] w_cap;
    logic [N_REQ-1:0] w_pnext;
    logic [IDX_W-1:0] w_pri;
    logic             w_ovf_hit;

    assign w_acc     = r_valid & bus.out_ready;
    assign w_clr     = w_acc ? (N_REQ'(1) << r_y) : '0;
    assign w_cap     = bus.en ? bus.req : '0;
    assign w_pnext   = (r_pending & ~w_clr) | w_cap;
    // A bit being retired by this accept may be re-requested without overflow.
    assign w_ovf_hit = |(w_cap & r_pending & ~w_clr);

    // Ascending scan so the highest set index is the last to assign.
    always_comb begin
        w_pri = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_pnext[i]) begin
                w_pri = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_pending <= '0;
            r_y       <= '0;
            r_valid   <= 1'b0;
            r_any     <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_pending <= w_pnext;
            r_any     <= |w_pnext;
            r_ovf     <= r_ovf | w_ovf_hit;
            case (r_state)
                S_IDLE: begin
                    if (|w_pnext) begin
                        r_y     <= w_pri;
                        r_valid <= 1'b1;
                        r_state <= S_VALID;
                    end
                end
                S_VALID: begin
                    // y is frozen until the consumer takes it.
                    if (w_acc) begin
                        if (|w_pnext) begin
                            r_y <= w_pri;
                        end else begin
                            r_valid <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.y         = r_y;
    assign bus.out_valid = r_valid;
    assign bus.any       = r_any;
    assign bus.ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_encoder_4_to_2_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_encoder_4_to_2_seq
// Brief   : Self-checking bench for encoder_4_to_2_seq with a request-set model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_encoder_4_to_2_seq;

    logic clk;
    logic rst;

    encoder_4_to_2_seq_if #(.N_REQ(4), .IDX_W(2)) bus ();

    encoder_4_to_2_seq #(.N_REQ(4), .IDX_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: the set of outstanding request indices plus the presented index.
    bit [3:0] m_pend;
    int       m_y;
    bit       m_valid;
    bit       m_ovf;
    bit       m_known = 1'b0;

    function automatic int highest(bit [3:0] s);
        for (int i = 3; i >= 0; i--) if (s[i]) return i;
        return 0;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(bit r, bit e, bit [3:0] q, bit rdy);
        bit taken;
        if (r) begin
            m_pend = '0; m_y = 0; m_valid = 1'b0; m_ovf = 1'b0;
            return;
        end
        taken = m_valid && rdy;
        for (int i = 0; i < 4; i++)
            if (e && q[i] && m_pend[i] && !(taken && m_y == i)) m_ovf = 1'b1;
        if (taken) m_pend[m_y] = 1'b0;
        if (e) m_pend = m_pend | q;
        if (!m_valid || taken) begin
            if (m_pend != 0) begin
                m_y = highest(m_pend);
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
        end
    endtask

    // Drive inputs, clock one edge, advance the model with what was sampled.
    task automatic step(bit r, bit e, bit [3:0] q, bit rdy);
        rst = r; bus.en = e; bus.req = q; bus.out_ready = rdy;
        @(posedge clk);
        model_edge(r, e, q, rdy);
        if (r) m_known = 1'b1;
        #2;
    endtask

    always @(negedge clk) begin
        if (m_known) begin
            chk("model_y",     32'(bus.y),         32'(m_y));
            chk("model_valid", 32'(bus.out_valid), 32'(m_valid));
            chk("model_any",   32'(bus.any),       32'(m_pend != 0));
            chk("model_ovf",   32'(bus.ovf),       32'(m_ovf));
        end
    end

    task automatic lit(string name, logic [1:0] ey, bit ev, bit ea, bit eo);
        chk({name, "_y"},     32'(bus.y),         32'(ey));
        chk({name, "_valid"}, 32'(bus.out_valid), 32'(ev));
        chk({name, "_any"},   32'(bus.any),       32'(ea));
        chk({name, "_ovf"},   32'(bus.ovf),       32'(eo));
    endtask

    logic [3:0] dec;

    initial begin
        rst = 1'b1; bus.en = 1'b0; bus.req = '0; bus.out_ready = 1'b0;

        // Reset, single request, hold, accept
        step(1, 0, 4'b0000, 0);
        step(1, 0, 4'b0000, 0);
        lit("reset", 2'd0, 0, 0, 0);
        step(0, 1, 4'b0100, 0);
        lit("single", 2'd2, 1, 1, 0);
        for (int k = 0; k < 5; k++) step(0, 1, 4'b0000, 0);
        lit("single_hold", 2'd2, 1, 1, 0);
        step(0, 1, 4'b0000, 1);
        lit("single_acc", 2'd2, 0, 0, 0);

        // Priority and drain order, with decoder loopback
        step(0, 1, 4'b1011, 1);
        lit("drain3", 2'd3, 1, 1, 0);
        dec = 4'b0001 << bus.y; chk("loop3", 32'(dec), 32'h8);
        step(0, 1, 4'b0000, 1);
        lit("drain1", 2'd1, 1, 1, 0);
        dec = 4'b0001 << bus.y; chk("loop1", 32'(dec), 32'h2);
        step(0, 1, 4'b0000, 1);
        lit("drain0", 2'd0, 1, 1, 0);
        dec = 4'b0001 << bus.y; chk("loop0", 32'(dec), 32'h1);
        step(0, 1, 4'b0000, 1);
        lit("drain_done", 2'd0, 0, 0, 0);

        // Overflow: re-arm on accept is not overflow; repeat while pending is
        step(1, 0, 4'b0000, 0);
        step(0, 1, 4'b0001, 0);
        lit("ovf_first", 2'd0, 1, 1, 0);
        step(0, 1, 4'b0001, 1);
        lit("ovf_rearm", 2'd0, 1, 1, 0);
        step(0, 1, 4'b0001, 0);
        lit("ovf_hit", 2'd0, 1, 1, 1);
        step(0, 1, 4'b0000, 1);
        lit("ovf_sticky", 2'd0, 0, 0, 1);
        step(1, 0, 4'b0000, 0);
        lit("ovf_clear", 2'd0, 0, 0, 0);

        // Enable gating
        for (int k = 0; k < 3; k++) step(0, 0, 4'b1111, 0);
        lit("en_gate", 2'd0, 0, 0, 0);
        step(0, 1, 4'b1111, 0);
        lit("en_on", 2'd3, 1, 1, 0);
        for (int k = 0; k < 4; k++) step(0, 0, 4'b0000, 1);
        lit("en_drain", 2'd0, 0, 0, 0);

        // Hold-stable: late higher-priority request waits for the accept
        step(0, 1, 4'b0010, 0);
        lit("hold_a", 2'd1, 1, 1, 0);
        step(0, 1, 4'b1000, 0);
        lit("hold_b", 2'd1, 1, 1, 0);
        step(0, 1, 4'b0000, 1);
        lit("hold_c", 2'd3, 1, 1, 0);
        step(0, 1, 4'b0000, 1);
        lit("hold_d", 2'd3, 0, 0, 0);

        // Reset mid-operation
        step(0, 1, 4'b1110, 0);
        lit("mid_pre", 2'd3, 1, 1, 0);
        step(1, 1, 4'b0001, 1);
        lit("mid_rst", 2'd0, 0, 0, 0);
        step(0, 1, 4'b0000, 1);
        lit("mid_after", 2'd0, 0, 0, 0);

        // Randomized traffic with occasional reset
        for (int k = 0; k < 3000; k++) begin
            bit r, e, rdy;
            bit [3:0] q;
            r   = ($urandom_range(0, 99) == 0);
            e   = ($urandom_range(0, 9) < 8);
            q   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
            rdy = ($urandom_range(0, 2) != 0);
            step(r, e, q, rdy);
        end

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
